// File: rtl/dpram_sdp.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port, no reset.
// Latency: read data appears one clk after a read-enabled cycle and holds while re=0.
// Backpressure: none; re freezes the read register, we gates the write.
// Ports:
//   clk          write and read clock
//   we/waddr/wdata  write port
//   re/raddr/rdata  registered read port
// Reading and writing the same address in one clk returns the old contents. The delay
// line never does this, so no bypass is provided.
module dpram_sdp #(
  parameter int width = 16,
  parameter int aw    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic             re,
  input  logic [aw-1:0]    raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [0:(1<<aw)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/reg_delay_var.sv
// Runtime-programmable multi-lane delay line built on a circular buffer in one SDP RAM.
// Latency: len_cur gated samples (0 = combinational passthrough); len changes apply one clk later.
// Backpressure: none; gate=0 freezes write pointer, fill count and output.
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   gate           sample enable, one capture per clk with gate=1
//   len            requested delay, saturated to maxlen
//   din / dout     nch lanes of dw bits, lane i at [i*dw +: dw]
//   dout_valid     dout carries real delayed data rather than flush zeros
//   len_cur        delay currently in effect
module reg_delay_var #(
  parameter int dw  = 16,
  parameter int nch = 1,
  parameter int aw  = 6,
  parameter int lw  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gate,
  input  logic [lw-1:0]     len,
  input  logic [nch*dw-1:0] din,
  output logic [nch*dw-1:0] dout,
  output logic              dout_valid,
  output logic [lw-1:0]     len_cur
);

  localparam int            maxlen   = 1 << aw;
  localparam logic [lw-1:0] maxlen_l = lw'(maxlen);
  localparam int            width    = nch * dw;

  logic [lw-1:0]    len_sat;
  logic             len_chg;
  logic [lw-1:0]    len_r;
  logic [aw-1:0]    wp;
  logic [aw-1:0]    rd_addr;
  logic [lw-1:0]    fill;
  logic [width-1:0] byp_q;
  logic [width-1:0] ram_q;
  logic [width-1:0] dout_reg;
  logic             ram_src;
  logic             live;

  assign len_sat = (len > maxlen_l) ? maxlen_l : len;
  assign len_chg = (len_sat != len_r);

  // Slot written L-1 captures before the current one. For L=maxlen the low aw bits of
  // len_r are zero, so the subtraction wraps to maxlen-1 as intended. The result equals
  // wp only for L=1, which takes the bypass register instead of the RAM.
  assign rd_addr = wp - (len_r[aw-1:0] - {{(aw-1){1'b0}}, 1'b1});

  dpram_sdp #(
    .width (width),
    .aw    (aw)
  ) u_ram (
    .clk   (clk),
    .we    (gate),
    .waddr (wp),
    .wdata (din),
    .re    (gate),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // Write pointer keeps advancing across length changes: the RAM history stays
  // contiguous, and the fill count alone decides when reads are trustworthy again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
    end else if (gate) begin
      wp <= wp + {{(aw-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_r <= '0;
    end else begin
      len_r <= len_sat;
    end
  end

  // A change of delay restarts the fill count; a capture in the same clk is written
  // to the RAM but deliberately not counted, since it belongs to neither length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill <= '0;
    end else if (len_chg) begin
      fill <= '0;
    end else if (gate && (fill != maxlen_l)) begin
      fill <= fill + {{(lw-1){1'b0}}, 1'b1};
    end
  end

  // The output register is split into a bypass register (L=1) and the RAM read
  // register (L>=2). ram_src picks which one the last capture loaded; live clears
  // on reset and on a length change so the combined register reads as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byp_q   <= '0;
      ram_src <= 1'b0;
      live    <= 1'b0;
    end else if (len_chg) begin
      byp_q   <= '0;
      ram_src <= 1'b0;
      live    <= 1'b0;
    end else if (gate) begin
      if (len_r == {{(lw-1){1'b0}}, 1'b1}) begin
        byp_q <= din;
      end
      ram_src <= (len_r > {{(lw-1){1'b0}}, 1'b1});
      live    <= 1'b1;
    end
  end

  assign dout_reg = live ? (ram_src ? ram_q : byp_q) : '0;

  assign dout_valid = (len_r == '0) | (fill >= len_r);
  assign len_cur    = len_r;

  // Mask keeps stale RAM contents (never cleared) off the output until the
  // buffer has been refilled at the current length.
  always_comb begin
    dout = '0;
    if (len_r == '0) begin
      dout = din;
    end else if (dout_valid) begin
      dout = dout_reg;
    end
  end

endmodule

// File: tb/tb_reg_delay_var.sv
module tb_reg_delay_var;

  localparam int DW     = 16;
  localparam int NCH    = 2;
  localparam int AW     = 6;
  localparam int LW     = 7;
  localparam int MAXLEN = 64;
  localparam int W      = DW * NCH;

  logic          clk = 1'b0;
  logic          reset;
  logic          gate;
  logic [LW-1:0] len;
  logic [W-1:0]  din;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic [LW-1:0] len_cur;

  always #5 clk = ~clk;

  reg_delay_var #(.dw(DW), .nch(NCH), .aw(AW), .lw(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .gate       (gate),
    .len        (len),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .len_cur    (len_cur)
  );

  typedef struct packed {
    logic [W-1:0]  dout;
    logic          valid;
    logic [LW-1:0] lenc;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] hist[$];
  int           m_len;
  int           m_fill;
  int           checks;
  int           errors;
  exp_t         e;

  // Two lanes carry distinct values so a lane swap would be visible.
  function automatic logic [W-1:0] mk(input int v);
    logic [DW-1:0] a;
    a = v[DW-1:0];
    return {a ^ 16'h8000, a};
  endfunction

  // Drive one clk of stimulus, advance the reference model and queue the expected
  // post-edge outputs. The model keeps the full capture history and indexes back L.
  task automatic drive(input logic g, input int v, input int l);
    int   sat;
    exp_t x;
    @(negedge clk);
    gate = g;
    din  = mk(v);
    len  = l[LW-1:0];
    sat  = (l > MAXLEN) ? MAXLEN : l;
    if (g) hist.push_back(din);
    if (sat != m_len) m_fill = 0;
    else if (g && m_fill < MAXLEN) m_fill++;
    m_len   = sat;
    x.lenc  = m_len[LW-1:0];
    x.valid = (m_len == 0) || (m_fill >= m_len);
    if (m_len == 0)   x.dout = din;
    else if (x.valid) x.dout = hist[hist.size() - m_len];
    else              x.dout = '0;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    gate  = 1'b0;
    len   = '0;
    din   = mk(16'h1234);
    #2;
    checks += 3;
    if (len_cur !== '0) begin errors++; $display("FAIL reset len_cur: got %0d expected 0", len_cur); end
    if (dout !== din) begin errors++; $display("FAIL reset dout: got %h expected %h", dout, din); end
    if (dout_valid !== 1'b1) begin errors++; $display("FAIL reset valid: got %b expected 1", dout_valid); end
    @(posedge clk);
    #3 reset = 1'b0;
  endtask

  task automatic test_len0();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 100 + i, 0);
      e = sb.pop_front();
      checks += 3;
      if (dout !== e.dout) begin errors++; $display("FAIL len0 dout: got %h expected %h", dout, e.dout); end
      if (dout_valid !== e.valid) begin errors++; $display("FAIL len0 valid: got %b expected %b", dout_valid, e.valid); end
      if (len_cur !== e.lenc) begin errors++; $display("FAIL len0 len_cur: got %0d expected %0d", len_cur, e.lenc); end
    end
    // Passthrough must follow din with no clock edge.
    din = mk(16'h0BEE);
    #1;
    checks++;
    if (dout !== mk(16'h0BEE)) begin errors++; $display("FAIL len0 comb: got %h expected %h", dout, mk(16'h0BEE)); end
  endtask

  task automatic test_len4();
    drive(1'b0, 0, 4);
    e = sb.pop_front();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, i, 4);
      e = sb.pop_front();
      checks += 4;
      if (dout !== e.dout) begin errors++; $display("FAIL len4 dout: got %h expected %h", dout, e.dout); end
      if (dout_valid !== e.valid) begin errors++; $display("FAIL len4 valid: got %b expected %b", dout_valid, e.valid); end
      if (len_cur !== e.lenc) begin errors++; $display("FAIL len4 len_cur: got %0d expected %0d", len_cur, e.lenc); end
      if (i < 4) begin
        if (dout[DW-1:0] !== 16'd0 || dout_valid !== 1'b0) begin
          errors++; $display("FAIL len4 early: got %h/%b expected 0/0", dout[DW-1:0], dout_valid);
        end
      end else if (dout[DW-1:0] !== 16'(i - 3) || dout_valid !== 1'b1) begin
        errors++; $display("FAIL len4 steady: got %0d/%b expected %0d/1", dout[DW-1:0], dout_valid, i - 3);
      end
    end
  endtask

  task automatic test_gate_toggle();
    drive(1'b0, 0, 5);
    e = sb.pop_front();
    for (int i = 1; i <= 16; i++) begin
      drive((i % 2) == 1, 200 + i, 5);
      e = sb.pop_front();
      checks += 3;
      if (dout !== e.dout) begin errors++; $display("FAIL gate dout: got %h expected %h", dout, e.dout); end
      if (dout_valid !== e.valid) begin errors++; $display("FAIL gate valid: got %b expected %b", dout_valid, e.valid); end
      if (len_cur !== e.lenc) begin errors++; $display("FAIL gate len_cur: got %0d expected %0d", len_cur, e.lenc); end
    end
  endtask

  task automatic test_maxlen();
    drive(1'b0, 0, MAXLEN);
    e = sb.pop_front();
    for (int i = 1; i <= 200; i++) begin
      drive(1'b1, 1000 + i, MAXLEN);
      e = sb.pop_front();
      checks += 4;
      if (dout !== e.dout) begin errors++; $display("FAIL maxlen dout: got %h expected %h", dout, e.dout); end
      if (dout_valid !== e.valid) begin errors++; $display("FAIL maxlen valid: got %b expected %b", dout_valid, e.valid); end
      if (len_cur !== e.lenc) begin errors++; $display("FAIL maxlen len_cur: got %0d expected %0d", len_cur, e.lenc); end
      if (dout_valid !== (i >= MAXLEN)) begin errors++; $display("FAIL maxlen vstart: got %b expected %b at %0d", dout_valid, i >= MAXLEN, i); end
    end
    // Oversized request saturates to the current length: no flush.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1300 + i, 100);
      e = sb.pop_front();
      checks += 3;
      if (dout !== e.dout) begin errors++; $display("FAIL sat dout: got %h expected %h", dout, e.dout); end
      if (dout_valid !== 1'b1) begin errors++; $display("FAIL sat valid: got %b expected 1", dout_valid); end
      if (len_cur !== 7'd64) begin errors++; $display("FAIL sat len_cur: got %0d expected 64", len_cur); end
    end
  endtask

  task automatic test_len_change();
    int l;
    for (int i = 0; i < 30; i++) begin
      // 4 for a while, 10 switched with a concurrent capture, then 6 switched while idle.
      l = (i < 8) ? 4 : (i < 22) ? 10 : 6;
      drive((i != 22), 2000 + i, l);
      e = sb.pop_front();
      checks += 3;
      if (dout !== e.dout) begin errors++; $display("FAIL lenchg dout: got %h expected %h at %0d", dout, e.dout, i); end
      if (dout_valid !== e.valid) begin errors++; $display("FAIL lenchg valid: got %b expected %b at %0d", dout_valid, e.valid, i); end
      if (len_cur !== e.lenc) begin errors++; $display("FAIL lenchg len_cur: got %0d expected %0d", len_cur, e.lenc); end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3000 + i, 3);
      e = sb.pop_front();
      checks++;
      if (dout !== e.dout) begin errors++; $display("FAIL mid pre dout: got %h expected %h", dout, e.dout); end
    end
    gate = 1'b0;
    #3 reset = 1'b1;
    din = mk(3777);
    #1;
    checks += 3;
    if (len_cur !== '0) begin errors++; $display("FAIL mid len_cur: got %0d expected 0", len_cur); end
    if (dout !== mk(3777)) begin errors++; $display("FAIL mid dout: got %h expected %h", dout, mk(3777)); end
    if (dout_valid !== 1'b1) begin errors++; $display("FAIL mid valid: got %b expected 1", dout_valid); end
    hist.delete();
    m_len  = 0;
    m_fill = 0;
    @(posedge clk);
    #3 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(i != 0, 3100 + i, 3);
      e = sb.pop_front();
      checks += 3;
      if (dout !== e.dout) begin errors++; $display("FAIL mid post dout: got %h expected %h", dout, e.dout); end
      if (dout_valid !== e.valid) begin errors++; $display("FAIL mid post valid: got %b expected %b", dout_valid, e.valid); end
      if (len_cur !== e.lenc) begin errors++; $display("FAIL mid post len_cur: got %0d expected %0d", len_cur, e.lenc); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_len  = 0;
    m_fill = 0;
    test_reset();
    test_len0();
    test_len4();
    test_gate_toggle();
    test_maxlen();
    test_len_change();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_delay_var.md
Name: reg_delay_var

Overview:
- Runtime-programmable, multi-channel delay line. Successor to the fixed-length shift-register delay.
- Delays nch lanes of dw-bit data by a length selected at run time (0..maxlen gated samples).
- Uses a circular buffer in one simple-dual-port RAM, shared by all lanes, plus a fill tracker that flags when output data is genuine.
- Sits in DSP/timing-alignment paths where the delay is trimmed by software.

Parameters:
- dw, 16, width of one channel.
- nch, 1, number of channels delayed in lockstep.
- aw, 6, address width; maxlen = 2**aw (power of two, so pointers wrap naturally).
- lw, 7, width of the len port; must satisfy 2**lw > maxlen.

Ports:
- clk  input  1  rising-edge clock; all logic is synchronous to it.
- reset  input  1  asynchronous, active-high reset.
- gate  input  1  sample enable; one capture per clk with gate=1.
- len  input  lw  requested delay in gated samples; values above maxlen saturate to maxlen.
- din  input  nch*dw  input lanes; lane i is din[i*dw +: dw].
- dout  output  nch*dw  delayed lanes.
- dout_valid  output  1  dout holds real delayed data, not flush zeros.
- len_cur  output  lw  delay currently in effect (registered, saturated).

Behaviour:
- len_r <= min(len, maxlen) every clk. len_cur = len_r. Delay changes take effect one clk after len changes.
- Reset (asynchronous):
  - wp, fill, len_r, dout_reg all clear to 0.
  - RAM is not cleared; output masking hides stale contents.
  - Output values during reset: len_cur = 0; len_r = 0 gives passthrough, so dout = din and dout_valid = 1.
- Capture on clk with gate=1:
  - mem[wp] <= din.
  - wp <= wp+1 (mod maxlen).
  - fill <= min(fill+1, maxlen).
- Output, with L = len_r and k = index of the latest capture:
  - L=0: dout = din combinationally; dout_valid = 1.
  - L=1: dout_reg <= din on capture.
  - L>=2: dout_reg <= mem[wp-(L-1)] on capture (address mod maxlen; synchronous RAM read).
  - After capture k, dout = din_(k-L+1). Cycle-for-cycle identical to a shift register of length L.
  - gate=0: wp, fill, dout_reg all hold.
- Valid and masking:
  - dout_valid = (L==0) | (fill >= L).
  - For L>=1, dout = dout_valid ? dout_reg : 0. Never expose stale RAM.
- Length change (registered len_r changes value):
  - That clk, fill <= 0 and dout_reg <= 0.
  - A concurrent capture still writes the RAM and advances wp but is not counted in fill.
  - Valid re-asserts after L further captures.
  - Changes while gate=0 flush identically.
  - Rewriting the same value has no effect.
- Boundaries:
  - L = maxlen reads the slot written maxlen-1 captures earlier; no read/write collision.
  - The read address is never equal to wp for L>=2. The RAM needs no read-during-write bypass.
  - fill saturates at maxlen; it must never wrap back below L.
  - Reset asserted mid-stream: outputs drop within the same cycle (asynchronous). After reset they follow the reset-value rules above.
- Lanes share wp, fill and the RAM; all lanes see identical latency.

Decomposition:
- No package; all sizing is by parameter. maxlen is a localparam = 1<<aw.
- One sub-module: dpram_sdp, a simple dual-port RAM.
  - Width nch*dw, depth 2**aw.
  - Synchronous write with write enable.
  - Synchronous read with read enable (gate).
  - No reset.
  - Infers block/distributed RAM.
- Top level holds wp, fill, len_r, the dout_reg bypass for L=1, the valid compare and the output mask.

Test Plan:
- len=0, nch=2, ramp din -> dout==din every cycle (combinational), dout_valid=1 throughout.
- len=4, gate=1 continuous, din=1,2,3,... -> dout=0 with valid=0 for the first 3 captures. After capture 4: dout=1, valid=1. Thereafter dout = din-3.
- len=5, gate toggling 1,0,1,0 -> output advances only on gated clks. After the 5th capture dout=din_1; values hold across gate=0.
- len=maxlen=64 for 200 captures -> dout = din_(k-63) across pointer wrap; valid from capture 64 on.
- len changed 4 -> 10 mid-stream -> len_cur=10 one clk later. dout=0, valid=0 for 9 captures, then dout=din_(k-9). Old RAM data never appears.
- Reset pulse for 1 clk, not edge-aligned, mid-stream with len=3 -> dout_reg/fill/len_r clear immediately: len_cur=0, passthrough (dout=din, valid=1). After reapplying len=3 and 2 captures, valid=0 and dout=0; valid=1 at the 3rd capture.
